// File: rtl/i2s_dac_tx_if.sv
// Bundle between the sample-index controller/codec side and the I2S DAC transmitter.
// The transmitter uses the slave view; whoever drives the codec clocks and sample uses master.
interface i2s_dac_tx_if #(
    parameter int DATA_W = 16
);
    logic              INIT_FINISH;
    logic [DATA_W-1:0] sample_data;
    logic              AUD_BCLK;
    logic              AUD_DACLRCK;
    logic              AUD_DACDAT;
    logic              data_over;
    logic              active;
    logic              short_frame;

    modport slave (
        input  INIT_FINISH, sample_data, AUD_BCLK, AUD_DACLRCK,
        output AUD_DACDAT, data_over, active, short_frame
    );

    modport master (
        output INIT_FINISH, sample_data, AUD_BCLK, AUD_DACLRCK,
        input  AUD_DACDAT, data_over, active, short_frame
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified serialiser slaved to the codec BCLK and DACLRCK.
// One sample is captured at each left-channel start and replayed on the right channel;
// a one-cycle data_over pulse per frame tells the controller to advance its index.
module i2s_dac_tx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter bit I2S_MODE    = 1'b1
) (
    input  logic           Clk,
    input  logic           Reset,
    i2s_dac_tx_if.slave    bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    // Synchronisers plus history flops for the two codec clocks
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic                   bclk_hist_q;
    logic                   lrck_hist_q;
    logic                   bclk_fall;
    logic                   lrck_fall;
    logic                   lrck_rise;

    // Transmitter state
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic                skip_q, skip_d;
    logic                dacdat_q, dacdat_d;
    logic                data_over_q, data_over_d;
    logic                short_q, short_d;

    // Decoded actions for the current cycle
    logic                word_start;
    logic                shift_step;
    logic [DATA_W-1:0]   word_src;

    // Bring BCLK and LRCK into the Clk domain and keep one cycle of history for edge detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            bclk_hist_q <= 1'b0;
            lrck_hist_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bus.AUD_BCLK};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], bus.AUD_DACLRCK};
            bclk_hist_q <= bclk_sync_q[SYNC_STAGES-1];
            lrck_hist_q <= lrck_sync_q[SYNC_STAGES-1];
        end
    end

    assign bclk_fall = bclk_hist_q & ~bclk_sync_q[SYNC_STAGES-1];
    assign lrck_fall = lrck_hist_q & ~lrck_sync_q[SYNC_STAGES-1];
    assign lrck_rise = ~lrck_hist_q & lrck_sync_q[SYNC_STAGES-1];

    // State register and all datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            bitcnt_q    <= '0;
            skip_q      <= 1'b0;
            dacdat_q    <= 1'b0;
            data_over_q <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            bitcnt_q    <= bitcnt_d;
            skip_q      <= skip_d;
            dacdat_q    <= dacdat_d;
            data_over_q <= data_over_d;
            short_q     <= short_d;
        end
    end

    // Next-state and datapath: an LRCK edge always wins over a coincident BCLK fall
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        bitcnt_d    = bitcnt_q;
        skip_d      = skip_q;
        dacdat_d    = dacdat_q;
        data_over_d = 1'b0;
        short_d     = short_q;
        word_start  = 1'b0;
        shift_step  = 1'b0;
        word_src    = hold_q;

        if (!bus.INIT_FINISH) begin
            state_d  = ST_IDLE;
            dacdat_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dacdat_d = 1'b0;
                    state_d  = ST_ALIGN;
                end
                ST_ALIGN: begin
                    dacdat_d = 1'b0;
                    if (lrck_fall) begin
                        word_start  = 1'b1;
                        word_src    = bus.sample_data;
                        hold_d      = bus.sample_data;
                        data_over_d = 1'b1;
                        state_d     = ST_LEFT;
                    end
                end
                ST_LEFT: begin
                    if (lrck_rise) begin
                        word_start = 1'b1;
                        word_src   = hold_q;
                        state_d    = ST_RIGHT;
                        if (bitcnt_q != '0) short_d = 1'b1;
                    end else if (bclk_fall) begin
                        shift_step = 1'b1;
                    end
                end
                ST_RIGHT: begin
                    if (lrck_fall) begin
                        word_start  = 1'b1;
                        word_src    = bus.sample_data;
                        hold_d      = bus.sample_data;
                        data_over_d = 1'b1;
                        state_d     = ST_LEFT;
                        if (bitcnt_q != '0) short_d = 1'b1;
                    end else if (bclk_fall) begin
                        shift_step = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    dacdat_d = 1'b0;
                end
            endcase
        end

        if (word_start) begin
            if (I2S_MODE) begin
                // MSB waits for the second BCLK fall; the first one is swallowed by skip
                shift_d  = word_src;
                bitcnt_d = CNT_W'(DATA_W);
                skip_d   = 1'b1;
            end else begin
                // Left-justified: MSB goes out together with the LRCK edge
                dacdat_d = word_src[DATA_W-1];
                shift_d  = {word_src[DATA_W-2:0], 1'b0};
                bitcnt_d = CNT_W'(DATA_W - 1);
                skip_d   = 1'b0;
            end
        end else if (shift_step) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else if (bitcnt_q != '0) begin
                dacdat_d = shift_q[DATA_W-1];
                shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                bitcnt_d = bitcnt_q - CNT_W'(1);
            end else begin
                dacdat_d = 1'b0;
            end
        end
    end

    assign bus.AUD_DACDAT  = dacdat_q;
    assign bus.data_over   = data_over_q;
    assign bus.short_frame = short_q;
    assign bus.active      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: one I2S-mode and one left-justified instance share a codec clock model.
// The I2S instance sees LRCK change a few Clk before the BCLK fall, the left-justified one
// sees LRCK change together with the BCLK fall.
module tb_i2s_dac_tx;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic          init_fin = 1'b0;
    logic [DW-1:0] samp_a = '0;
    logic [DW-1:0] samp_b = '0;

    // Codec clock model: BCLK = Clk/16, 'half' BCLK periods per channel
    logic [3:0] ph = 4'd0;
    int         bitn = 0;
    int         half = 32;
    logic       wrap_pend = 1'b0;
    logic       bclk = 1'b1;
    logic       lrck_lj = 1'b1;
    logic       lrck_i2s = 1'b1;

    i2s_dac_tx_if #(.DATA_W(DW)) bus_a ();
    i2s_dac_tx_if #(.DATA_W(DW)) bus_b ();

    assign bus_a.INIT_FINISH = init_fin;
    assign bus_a.sample_data = samp_a;
    assign bus_a.AUD_BCLK    = bclk;
    assign bus_a.AUD_DACLRCK = lrck_i2s;
    assign bus_b.INIT_FINISH = init_fin;
    assign bus_b.sample_data = samp_b;
    assign bus_b.AUD_BCLK    = bclk;
    assign bus_b.AUD_DACLRCK = lrck_lj;

    i2s_dac_tx #(.DATA_W(DW), .SYNC_STAGES(2), .I2S_MODE(1'b1)) dut_a (
        .Clk(clk), .Reset(rst), .bus(bus_a.slave));
    i2s_dac_tx #(.DATA_W(DW), .SYNC_STAGES(2), .I2S_MODE(1'b0)) dut_b (
        .Clk(clk), .Reset(rst), .bus(bus_b.slave));

    // Codec clock generator
    always @(posedge clk) begin
        ph <= ph + 4'd1;
        if (ph == 4'd3) begin
            wrap_pend <= (bitn >= half - 1);
            if (bitn >= half - 1) lrck_i2s <= ~lrck_i2s;
        end
        if (ph == 4'd7) begin
            bclk <= 1'b0;
            if (wrap_pend) begin
                bitn    <= 0;
                lrck_lj <= ~lrck_lj;
            end else begin
                bitn <= bitn + 1;
            end
        end
        if (ph == 4'd15) bclk <= 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected bits pushed at each BCLK fall, popped at the following BCLK rise
    typedef struct packed {
        logic v;
        logic care;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb, pa, pb;
    bit   armed = 0, run = 0, first = 0, dov_run = 0;
    logic last_a = 1'b0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    int   cnt_a = 0, cnt_b = 0;

    initial forever begin
        @(negedge clk);
        if (!armed) begin
            run = 0; dov_run = 0; cnt_a = 0; cnt_b = 0;
            qa.delete(); qb.delete();
        end
        if (ph == 4'd8) begin
            if (armed && !run && bitn == 0 && !lrck_lj) begin
                run = 1; first = 1;
            end
            if (run) begin
                // I2S: bit 0 repeats the previous line state, then MSB-first, then zero padding
                ea.care = !(first && bitn == 0);
                if (bitn == 0)       ea.v = last_a;
                else if (bitn <= DW) ea.v = samp_a[DW-bitn];
                else                 ea.v = 1'b0;
                last_a = ea.v;
                // Left-justified: MSB on bit 0
                eb.care = 1'b1;
                eb.v    = (bitn < DW) ? samp_b[DW-1-bitn] : 1'b0;
                qa.push_back(ea);
                qb.push_back(eb);
                first = 0;
                if (bitn == half / 2 && !lrck_lj) begin
                    if (dov_run) begin
                        chk("dover_per_frame_a", 32'(cnt_a), 32'd1);
                        chk("dover_per_frame_b", 32'(cnt_b), 32'd1);
                    end
                    cnt_a = 0; cnt_b = 0; dov_run = 1;
                end
            end
        end
        if (ph == 4'd0 && run && qa.size() > 0 && qb.size() > 0) begin
            pa = qa.pop_front();
            pb = qb.pop_front();
            if (pa.care) chk($sformatf("bit_i2s_j%0d", bitn), 32'(bus_a.AUD_DACDAT), 32'(pa.v));
            chk($sformatf("bit_lj_j%0d", bitn), 32'(bus_b.AUD_DACDAT), 32'(pb.v));
        end
        if (bus_a.data_over) begin
            if (run) chk("dover_gap_a", 32'(prev_a), 32'd0);
            cnt_a++;
        end
        if (bus_b.data_over) begin
            if (run) chk("dover_gap_b", 32'(prev_b), 32'd0);
            cnt_b++;
        end
        prev_a = bus_a.data_over;
        prev_b = bus_b.data_over;
    end

    // Wait for the middle of a left channel (bounded)
    task automatic wait_mid();
        bit found = 0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (ph == 4'd8 && bitn == half / 2 && !lrck_lj) found = 1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL wait_mid timeout actual=none required=left-mid");
        end
    endtask

    // Wait for a given channel / bit / phase position (bounded)
    task automatic wait_pos(input logic lr, input int n, input logic [3:0] p);
        bit found = 0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (lrck_lj == lr && bitn == n && ph == p) found = 1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL wait_pos timeout actual=none required=lr%0b bit%0d", lr, n);
        end
    endtask

    typedef struct {
        int          half;
        logic [15:0] sa;
        logic [15:0] sb;
        int          frames;
        logic        exp_short;
    } vec_t;
    vec_t vt[4];

    logic [2:0] acc_a, acc_b;
    int         n0, na, nb;
    bit         seen;

    initial begin
        vt[0] = '{32, 16'hA5C3, 16'h8001, 4, 1'b0};
        vt[1] = '{32, 16'h0001, 16'hFFFF, 2, 1'b0};
        vt[2] = '{32, 16'hFFFF, 16'h7FFE, 2, 1'b0};
        vt[3] = '{8,  16'hA5C3, 16'h8001, 6, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dacdat_a", 32'(bus_a.AUD_DACDAT), 32'd0);
        chk("rst_dover_a",  32'(bus_a.data_over),  32'd0);
        chk("rst_active_a", 32'(bus_a.active),     32'd0);
        chk("rst_short_a",  32'(bus_a.short_frame),32'd0);
        chk("rst_dacdat_b", 32'(bus_b.AUD_DACDAT), 32'd0);
        chk("rst_active_b", 32'(bus_b.active),     32'd0);
        rst = 1'b0;

        // Clocks running, INIT_FINISH low for two frames: outputs stay quiet
        acc_a = '0; acc_b = '0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            acc_a |= {bus_a.AUD_DACDAT, bus_a.data_over, bus_a.active};
            acc_b |= {bus_b.AUD_DACDAT, bus_b.data_over, bus_b.active};
        end
        chk("idle_outputs_a", 32'(acc_a), 32'd0);
        chk("idle_outputs_b", 32'(acc_b), 32'd0);

        // Table-driven frame runs
        for (int r = 0; r < 4; r++) begin
            armed = 0;
            half  = vt[r].half;
            wait_mid();
            samp_a   = vt[r].sa;
            samp_b   = vt[r].sb;
            init_fin = 1'b1;
            armed    = 1;
            repeat (vt[r].frames + 1) wait_mid();
            chk($sformatf("row%0d_active_a", r), 32'(bus_a.active), 32'd1);
            chk($sformatf("row%0d_short_a", r), 32'(bus_a.short_frame), 32'(vt[r].exp_short));
            chk($sformatf("row%0d_short_b", r), 32'(bus_b.short_frame), 32'(vt[r].exp_short));
        end

        // Drop INIT_FINISH mid left word, re-raise during right half
        armed = 0;
        wait_pos(1'b0, 3, 4'd10);
        init_fin = 1'b0;
        @(posedge clk); #1;
        chk("drop_active_a", 32'(bus_a.active), 32'd0);
        chk("drop_active_b", 32'(bus_b.active), 32'd0);
        chk("drop_dacdat_a", 32'(bus_a.AUD_DACDAT), 32'd0);
        chk("drop_dacdat_b", 32'(bus_b.AUD_DACDAT), 32'd0);
        wait_pos(1'b1, 3, 4'd10);
        init_fin = 1'b1;
        n0 = 0; seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (lrck_i2s == 1'b0) seen = 1;
            else if (bus_a.data_over || bus_b.data_over) n0++;
        end
        chk("realign_lrck_seen", 32'(seen), 32'd1);
        chk("realign_no_dover", 32'(n0), 32'd0);
        na = 0; nb = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus_a.data_over) na++;
            if (bus_b.data_over) nb++;
        end
        chk("realign_dover_a", 32'(na), 32'd1);
        chk("realign_dover_b", 32'(nb), 32'd1);
        wait_mid();
        armed = 1;
        repeat (4) wait_mid();

        // Asynchronous reset between Clk edges mid-shift
        armed = 0;
        wait_pos(1'b0, 3, 4'd14);
        #2 rst = 1'b1;
        #1;
        chk("arst_dacdat_a", 32'(bus_a.AUD_DACDAT), 32'd0);
        chk("arst_dover_a",  32'(bus_a.data_over),  32'd0);
        chk("arst_active_a", 32'(bus_a.active),     32'd0);
        chk("arst_short_a",  32'(bus_a.short_frame),32'd0);
        chk("arst_dacdat_b", 32'(bus_b.AUD_DACDAT), 32'd0);
        chk("arst_dover_b",  32'(bus_b.data_over),  32'd0);
        chk("arst_active_b", 32'(bus_b.active),     32'd0);
        chk("arst_short_b",  32'(bus_b.short_frame),32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
